exec_hazard_ctrl: RTL and testbench

Pipeline controller for the dual-issue (upper/lower slot) execute stage. It watches the bundle leaving decode and the load currently handed from execute to memory. It drives the execute stage's `interlock` and `exec_stall` inputs so that load-use hazards and variable-latency memory responses are sequenced safely. It also keeps a sticky timeout error and a saturating stall-cycle counter for debug.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/exec_hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_match.sv | 28 ++
 rtl/exec_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_exec_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [5:0]  LOAD_OPCODE = 6'b010000;
    localparam logic [63:0] NOP_BUNDLE  = {3'b111, 29'b0, 3'b111, 29'b0};

    typedef struct packed {
        logic [4:0] rt;
        logic       flag;
    } dest_t;

    localparam dest_t DEST_NONE = '{rt: 5'd0, flag: 1'b0};

endpackage

// File: rtl/exec_hazard_ctrl_if.sv
// Decode/execute/memory sideband seen by the hazard controller, plus its outputs.
interface exec_hazard_ctrl_if;

    logic        d_valid;
    logic [4:0]  d_u_ra;
    logic [4:0]  d_u_rb;
    logic [4:0]  d_l_ra;
    logic [4:0]  d_l_rb;
    logic        d_u_ra_use;
    logic        d_u_rb_use;
    logic        d_l_ra_use;
    logic        d_l_rb_use;
    logic        ex_load;
    logic [4:0]  ex_u_rt;
    logic [4:0]  ex_l_rt;
    logic        ex_u_rt_flag;
    logic        ex_l_rt_flag;
    logic        mem_ack;
    logic        interlock;
    logic        exec_stall;
    logic        err;
    logic [31:0] stall_cnt;

    modport master (
        output d_valid, d_u_ra, d_u_rb, d_l_ra, d_l_rb,
        output d_u_ra_use, d_u_rb_use, d_l_ra_use, d_l_rb_use,
        output ex_load, ex_u_rt, ex_l_rt, ex_u_rt_flag, ex_l_rt_flag,
        output mem_ack,
        input  interlock, exec_stall, err, stall_cnt
    );

    modport slave (
        input  d_valid, d_u_ra, d_u_rb, d_l_ra, d_l_rb,
        input  d_u_ra_use, d_u_rb_use, d_l_ra_use, d_l_rb_use,
        input  ex_load, ex_u_rt, ex_l_rt, ex_u_rt_flag, ex_l_rt_flag,
        input  mem_ack,
        output interlock, exec_stall, err, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Compares the four decode sources against an upper/lower destination pair.
module hazard_match (
    input  logic            d_valid_i,
    input  logic [3:0][4:0] src_i,
    input  logic [3:0]      use_i,
    input  logic [4:0]      u_rt_i,
    input  logic            u_flag_i,
    input  logic [4:0]      l_rt_i,
    input  logic            l_flag_i,
    output logic            hit_o
);

    logic u_hit;
    logic l_hit;

    always_comb begin
        u_hit = 1'b0;
        l_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (use_i[i] && (src_i[i] == u_rt_i)) u_hit = 1'b1;
            if (use_i[i] && (src_i[i] == l_rt_i)) l_hit = 1'b1;
        end
    end

    // Register 0 deliberately matches like any other register.
    assign hit_o = d_valid_i & ((u_flag_i & u_hit) | (l_flag_i & l_hit));

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Sequences load-use interlocks and variable-latency memory stalls for execute.
module exec_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    exec_hazard_ctrl_if.slave  bus
);

    localparam int               WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);

    ctrl_state_t    state_q, state_d;
    dest_t          pend_u_q, pend_u_d;
    dest_t          pend_l_q, pend_l_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           err_q, err_d;
    logic [31:0]    stall_cnt_q, stall_cnt_d;

    logic           ex_hit;
    logic           pend_hit;
    logic           timeout;
    logic           interlock;
    logic           exec_stall;
    logic [3:0][4:0] dec_src;
    logic [3:0]      dec_use;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign dec_src = {bus.d_u_ra, bus.d_u_rb, bus.d_l_ra, bus.d_l_rb};
    assign dec_use = {bus.d_u_ra_use, bus.d_u_rb_use, bus.d_l_ra_use, bus.d_l_rb_use};

    hazard_match u_ex_match (
        .d_valid_i (bus.d_valid),
        .src_i     (dec_src),
        .use_i     (dec_use),
        .u_rt_i    (bus.ex_u_rt),
        .u_flag_i  (bus.ex_u_rt_flag),
        .l_rt_i    (bus.ex_l_rt),
        .l_flag_i  (bus.ex_l_rt_flag),
        .hit_o     (ex_hit)
    );

    hazard_match u_pend_match (
        .d_valid_i (bus.d_valid),
        .src_i     (dec_src),
        .use_i     (dec_use),
        .u_rt_i    (pend_u_q.rt),
        .u_flag_i  (pend_u_q.flag),
        .l_rt_i    (pend_l_q.rt),
        .l_flag_i  (pend_l_q.flag),
        .hit_o     (pend_hit)
    );

    assign timeout = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.ex_load) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.mem_ack || timeout) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Both outputs drop in the ack cycle: load data is forwarded from memory.
    always_comb begin
        interlock  = 1'b0;
        exec_stall = 1'b0;
        case (state_q)
            RUN: begin
                interlock = bus.ex_load & ex_hit;
            end
            MEM_WAIT: begin
                exec_stall = ~bus.mem_ack;
                interlock  = ~bus.mem_ack & pend_hit;
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_u_d    = pend_u_q;
        pend_l_d    = pend_l_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_cnt_d = (interlock | exec_stall) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.mem_ack) err_d = 1'b1;
                if (bus.ex_load) begin
                    pend_u_d   = '{rt: bus.ex_u_rt, flag: bus.ex_u_rt_flag};
                    pend_l_d   = '{rt: bus.ex_l_rt, flag: bus.ex_l_rt_flag};
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                // A load while execute should be bubbling is flagged, never latched.
                if (bus.ex_load) err_d = 1'b1;
                if (bus.mem_ack) begin
                    pend_u_d.flag = 1'b0;
                    pend_l_d.flag = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (timeout) begin
                        err_d         = 1'b1;
                        pend_u_d.flag = 1'b0;
                        pend_l_d.flag = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_u_q.flag <= 1'b0;
            pend_l_q.flag <= 1'b0;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            pend_u_q.flag <= pend_u_d.flag;
            pend_l_q.flag <= pend_l_d.flag;
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Register numbers are only meaningful while their flag is set.
    always_ff @(posedge clk) begin
        pend_u_q.rt <= pend_u_d.rt;
        pend_l_q.rt <= pend_l_d.rt;
    end

    assign bus.interlock  = interlock;
    assign bus.exec_stall = exec_stall;
    assign bus.err        = err_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_exec_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exec_hazard_ctrl_if bus ();

    exec_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [4:0] s0, s1, s2, s3;
        logic [3:0] uses;
        logic       ld;
        logic [4:0] urt;
        logic       uf;
        logic [4:0] lrt;
        logic       lf;
        logic       exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_dec(input logic dv, input logic [4:0] a, b, c, d, input logic [3:0] u);
        bus.d_valid    = dv;
        bus.d_u_ra     = a;
        bus.d_u_rb     = b;
        bus.d_l_ra     = c;
        bus.d_l_rb     = d;
        bus.d_u_ra_use = u[3];
        bus.d_u_rb_use = u[2];
        bus.d_l_ra_use = u[1];
        bus.d_l_rb_use = u[0];
    endtask

    task automatic set_ex(input logic ld, input logic [4:0] urt, input logic uf,
                          input logic [4:0] lrt, input logic lf);
        bus.ex_load      = ld;
        bus.ex_u_rt      = urt;
        bus.ex_u_rt_flag = uf;
        bus.ex_l_rt      = lrt;
        bus.ex_l_rt_flag = lf;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_dec(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000);
        set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.mem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd5, 4'b0001, 1'b1, 5'd5,  1'b1, 5'd9, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 5'd1, 5'd2, 5'd3, 5'd5, 4'b0001, 1'b1, 5'd5,  1'b1, 5'd9, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd5, 4'b1110, 1'b1, 5'd5,  1'b1, 5'd9, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd5, 4'b0001, 1'b1, 5'd5,  1'b0, 5'd9, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0110, 1'b1, 5'd30, 1'b1, 5'd3, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 5'd0, 5'd2, 5'd3, 5'd4, 4'b1000, 1'b1, 5'd0,  1'b1, 5'd8, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd5, 4'b0001, 1'b0, 5'd5,  1'b1, 5'd9, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 4'b1111, 1'b1, 5'd7,  1'b1, 5'd8, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0100, 1'b1, 5'd2,  1'b1, 5'd8, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0010, 1'b1, 5'd9,  1'b1, 5'd3, 1'b0, 1'b0};

        // Reset state with an idle decode.
        do_reset();
        settle();
        chk("reset_interlock", 32'(bus.interlock), 32'd0);
        chk("reset_stall", 32'(bus.exec_stall), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_cnt", bus.stall_cnt, 32'd0);

        // Vector table: load cycle, one MEM_WAIT cycle, ack cycle.
        for (int i = 0; i < 10; i++) begin
            tick();
            set_dec(vecs[i].dv, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].uses);
            set_ex(vecs[i].ld, vecs[i].urt, vecs[i].uf, vecs[i].lrt, vecs[i].lf);
            bus.mem_ack = 1'b0;
            settle();
            chk($sformatf("vec%0d_run_il", i), 32'(bus.interlock), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_run_stall", i), 32'(bus.exec_stall), 32'd0);
            if (vecs[i].ld) begin
                tick();
                set_ex(1'b0, 5'd31, 1'b1, 5'd31, 1'b1);
                settle();
                chk($sformatf("vec%0d_wait_il", i), 32'(bus.interlock), 32'(vecs[i].exp));
                chk($sformatf("vec%0d_wait_stall", i), 32'(bus.exec_stall), 32'd1);
                tick();
                bus.mem_ack = 1'b1;
                settle();
                chk($sformatf("vec%0d_ack_il", i), 32'(bus.interlock), 32'd0);
                chk($sformatf("vec%0d_ack_stall", i), 32'(bus.exec_stall), 32'd0);
            end
        end
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("vec_err", 32'(bus.err), 32'd0);

        // Load-use on lower rb, ack on the 4th MEM_WAIT cycle (coincides with timeout).
        do_reset();
        set_dec(1'b1, 5'd1, 5'd2, 5'd3, 5'd5, 4'b0001);
        set_ex(1'b1, 5'd5, 1'b1, 5'd9, 1'b0);
        settle();
        chk("lu_t0_il", 32'(bus.interlock), 32'd1);
        chk("lu_t0_stall", 32'(bus.exec_stall), 32'd0);
        for (int t = 1; t <= 3; t++) begin
            tick();
            set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            settle();
            chk($sformatf("lu_t%0d_il", t), 32'(bus.interlock), 32'd1);
            chk($sformatf("lu_t%0d_stall", t), 32'(bus.exec_stall), 32'd1);
        end
        tick();
        bus.mem_ack = 1'b1;
        settle();
        chk("lu_ack_il", 32'(bus.interlock), 32'd0);
        chk("lu_ack_stall", 32'(bus.exec_stall), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("lu_cnt", bus.stall_cnt, 32'd4);
        chk("lu_err", 32'(bus.err), 32'd0);
        chk("lu_run_stall", 32'(bus.exec_stall), 32'd0);

        // Load to r7 with an unrelated decode bundle, ack after two wait cycles.
        do_reset();
        set_dec(1'b1, 5'd1, 5'd2, 5'd3, 5'd4, 4'b1111);
        set_ex(1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        n = 0;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                tick();
                set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
                bus.mem_ack = (t == 3);
            end
            settle();
            chk($sformatf("nl_t%0d_il", t), 32'(bus.interlock), 32'd0);
            if (bus.exec_stall) n++;
        end
        chk("nl_stall_cycles", 32'(n), 32'd2);
        bus.mem_ack = 1'b0;
        chk("nl_cnt", bus.stall_cnt, 32'd2);

        // Timeout with no ack.
        do_reset();
        set_ex(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        n = 0;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) begin
                tick();
                set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            end
            settle();
            if (bus.exec_stall) n++;
        end
        chk("to_stall_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_cnt", bus.stall_cnt, 32'd4);
        chk("to_run_stall", 32'(bus.exec_stall), 32'd0);

        // Reset during the 2nd MEM_WAIT cycle.
        do_reset();
        set_dec(1'b1, 5'd5, 5'd2, 5'd3, 5'd4, 4'b1000);
        set_ex(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b1;
        settle();
        chk("rw_pre_stall", 32'(bus.exec_stall), 32'd1);
        tick();
        rst = 1'b0;
        settle();
        chk("rw_il", 32'(bus.interlock), 32'd0);
        chk("rw_stall", 32'(bus.exec_stall), 32'd0);
        chk("rw_err", 32'(bus.err), 32'd0);
        chk("rw_cnt", bus.stall_cnt, 32'd0);

        // mem_ack while in RUN.
        do_reset();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        set_ex(1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
        settle();
        chk("ar_err", 32'(bus.err), 32'd1);
        chk("ar_stall", 32'(bus.exec_stall), 32'd0);
        tick();
        set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("ar_wait_stall", 32'(bus.exec_stall), 32'd1);
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("ar_back_run", 32'(bus.exec_stall), 32'd0);

        // ex_load while in MEM_WAIT.
        do_reset();
        set_dec(1'b1, 5'd5, 5'd2, 5'd3, 5'd4, 4'b1000);
        set_ex(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        set_ex(1'b1, 5'd9, 1'b1, 5'd9, 1'b1);
        settle();
        chk("lw_t1_il", 32'(bus.interlock), 32'd1);
        chk("lw_t1_err", 32'(bus.err), 32'd0);
        tick();
        set_ex(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("lw_t2_err", 32'(bus.err), 32'd1);
        chk("lw_t2_il", 32'(bus.interlock), 32'd1);
        chk("lw_t2_stall", 32'(bus.exec_stall), 32'd1);
        tick();
        bus.mem_ack = 1'b1;
        settle();
        chk("lw_ack_stall", 32'(bus.exec_stall), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        chk("lw_run_stall", 32'(bus.exec_stall), 32'd0);
        chk("lw_run_il", 32'(bus.interlock), 32'd0);
        chk("lw_cnt", bus.stall_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
